fetch_pipe: RTL and testbench
=============================

Name: fetch_pipe

Overview:
- Implements the instruction-side pipeline for the 3-stage RV32I core (FD, X, MW).
- Consumes `pc_sel` from the hazard/branch control logic and owns the PC register, the next-PC mux, the synchronous IMEM address, and the FD->X->MW instruction/PC pipeline registers.
- On redirect it injects bubbles; it also keeps cycle and instret counters for the CSR block.
- It is the producer of the `inst_fd`/`inst_x`/`inst_mw` words that the control logic decodes.

Parameters:
- RESET_PC, 32'h4000_0000, address of the first fetch after reset (BIOS base).
- NOP_INST, 32'h0000_0013, encoding injected as a bubble (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_sel  in  2  0 = JAL target from FD, 1 = redirect from X (JALR / taken branch), 2 = PC+4; value 3 treated as 2.
- jal_target  in  32  JAL target computed in FD (pc_fd + J-imm).
- alu_out  in  32  X-stage ALU result, used as redirect target.
- stall  in  1  freeze FD (hold PC, re-fetch same address, bubble into X).
- imem_addr  out  32  IMEM/BIOS read address; data returns one cycle later on imem_dout.
- imem_dout  in  32  synchronous-read instruction data.
- pc_fd  out  32  PC of the instruction currently on imem_dout.
- inst_fd  out  32  = imem_dout (combinational pass-through).
- inst_x, pc_x, valid_x  out  32,32,1  X-stage registers.
- inst_mw, pc_mw, valid_mw  out  32,32,1  MW-stage registers.
- cycle_cnt  out  32  free-running cycle counter.
- instret_cnt  out  32  retired-instruction counter.

Behaviour:
- Reset (rst=1, synchronous, any cycle including mid-redirect or mid-stall):
  - imem_addr = RESET_PC (combinational override), so the first post-reset cycle sees RESET_PC's word on imem_dout.
  - Next edge: pc_fd <= RESET_PC; inst_x, inst_mw <= NOP_INST; pc_x, pc_mw <= 0; valid_x, valid_mw <= 0; cycle_cnt, instret_cnt <= 0.
  - rst must be held at least 1 cycle.
- Next-PC (combinational, drives imem_addr when rst=0), priority high to low:
  - pc_sel==1: alu_out & ~32'h1 (JALR LSB clear).
  - stall: pc_fd (re-read).
  - pc_sel==0: jal_target.
  - otherwise: pc_fd + 4, wrapping modulo 2^32.
- Edge update: pc_fd <= next-PC.
- FD->X transfer:
  - pc_sel==1: the FD instruction is wrong-path. inst_x <= NOP_INST, valid_x <= 0. This kill overrides stall.
  - else if stall: inst_x <= NOP_INST, valid_x <= 0. pc_fd is held via the re-read address.
  - else: inst_x <= inst_fd, pc_x <= pc_fd, valid_x <= 1. A JAL in FD with pc_sel==0 proceeds to X (it must write rd).
- X->MW: always advances: inst_mw <= inst_x, pc_mw <= pc_x, valid_mw <= valid_x. It is never stalled or killed.
- Redirect penalty:
  - X redirect costs exactly 1 bubble.
  - JAL in FD costs 0 bubbles.
- Counters:
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments on cycles where valid_mw==1.
  - Both wrap 2^32-1 -> 0.
- Latency: an instruction addressed in cycle N is in FD in N+1, X in N+2, MW in N+3.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INST, RESET_PC default
  - PC_SEL_JAL=0, PC_SEL_ALU=1, PC_SEL_PC4=2
  - opcode constants already used by the control logic
- One natural sub-module: pipe_stage_reg (inst/pc/valid register with rst-to-NOP and kill input), instantiated for X and MW. Everything else is inline.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles.
  - Required: imem_addr=0x4000_0000 throughout; after release inst_x=inst_mw=0x0000_0013, valid_x=valid_mw=0, both counters 0; pc_fd=0x4000_0000.
- Sequential fetch:
  - Stimulus: pc_sel=2 for 4 cycles.
  - Required: imem_addr 0x4000_0004, _0008, _000C, _0010; pc_x trails pc_fd by 1 cycle, pc_mw by 2; instret_cnt=1 in the cycle after the first valid_mw.
- JAL in FD:
  - Stimulus: pc_sel=0, jal_target=0x4000_0100.
  - Required: imem_addr=0x4000_0100; next cycle the JAL is in X with valid_x=1, no bubble.
- X redirect:
  - Stimulus: pc_sel=1, alu_out=0x4000_0201.
  - Required: imem_addr=0x4000_0200; next inst_x=0x13, valid_x=0; instret_cnt not incremented when that bubble reaches MW.
- Stall then redirect collision:
  - Stimulus: stall=1 for 2 cycles, then stall=1 together with pc_sel=1, alu_out=0x4000_0040.
  - Required: during plain stall imem_addr=pc_fd and pc_fd unchanged, two bubbles into X; in the collision cycle imem_addr=0x4000_0040.
- Reset mid-redirect and counter wrap:
  - Stimulus: assert rst in the same cycle as pc_sel=1.
  - Required: imem_addr=RESET_PC and the pipeline clears.
  - Stimulus: force instret_cnt=0xFFFF_FFFF with valid_mw=1.
  - Required: instret_cnt reads 0 the next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the 3-stage RV32I core: bubble encoding, boot
// address, next-PC select codes and the base opcodes the decoder uses.
package riscv_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

  localparam logic [1:0] PC_SEL_JAL = 2'd0;
  localparam logic [1:0] PC_SEL_ALU = 2'd1;
  localparam logic [1:0] PC_SEL_PC4 = 2'd2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // JALR targets always have their least significant bit cleared.
  function automatic logic [31:0] clear_lsb(input logic [31:0] addr);
    return addr & ~32'h1;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register holding an instruction word, its PC and a
// valid flag. Reset or kill turns the stage into a NOP bubble.
module pipe_stage_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] BUBBLE = riscv_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_kill,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic        i_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_valid;

  // Load the next stage contents; a killed slot keeps its PC for debug
  // visibility but carries a NOP and is marked invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst  <= BUBBLE;
      r_pc    <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_kill) begin
      r_inst  <= BUBBLE;
      r_pc    <= i_pc;
      r_valid <= 1'b0;
    end else begin
      r_inst  <= i_inst;
      r_pc    <= i_pc;
      r_valid <= i_valid;
    end
  end

  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_pipe.sv
// Instruction-side pipeline of the 3-stage core: PC register, next-PC
// mux, IMEM address, FD->X->MW registers and the cycle/instret counters.
module fetch_pipe
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] jal_target,
  input  logic [31:0] alu_out,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [31:0] pc_fd,
  output logic [31:0] inst_fd,
  output logic [31:0] inst_x,
  output logic [31:0] pc_x,
  output logic        valid_x,
  output logic [31:0] inst_mw,
  output logic [31:0] pc_mw,
  output logic        valid_mw,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  logic [31:0] r_pc_fd;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;
  logic [31:0] w_next_pc;
  logic        w_kill_x;

  // Next-PC selection: an X redirect beats a stall, a stall beats a JAL,
  // and anything else (including the unused code 3) falls through to PC+4.
  always_comb begin
    w_next_pc = r_pc_fd + 32'd4;
    if (pc_sel == PC_SEL_ALU) begin
      w_next_pc = clear_lsb(alu_out);
    end else if (stall) begin
      w_next_pc = r_pc_fd;
    end else if (pc_sel == PC_SEL_JAL) begin
      w_next_pc = jal_target;
    end
  end

  // Reset overrides the address so the boot word is already on imem_dout
  // in the first cycle after reset is released.
  assign imem_addr = rst ? RESET_PC : w_next_pc;

  // The FD PC is always the address presented one cycle earlier.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_fd <= RESET_PC;
    end else begin
      r_pc_fd <= w_next_pc;
    end
  end

  assign pc_fd   = r_pc_fd;
  assign inst_fd = imem_dout;

  // The FD word is wrong-path on an X redirect and must wait on a stall;
  // either way X receives a bubble.
  assign w_kill_x = (pc_sel == PC_SEL_ALU) || stall;

  pipe_stage_reg #(
    .BUBBLE (NOP_INST)
  ) u_stage_x (
    .clk     (clk),
    .rst     (rst),
    .i_kill  (w_kill_x),
    .i_inst  (inst_fd),
    .i_pc    (r_pc_fd),
    .i_valid (1'b1),
    .o_inst  (inst_x),
    .o_pc    (pc_x),
    .o_valid (valid_x)
  );

  pipe_stage_reg #(
    .BUBBLE (NOP_INST)
  ) u_stage_mw (
    .clk     (clk),
    .rst     (rst),
    .i_kill  (1'b0),
    .i_inst  (inst_x),
    .i_pc    (pc_x),
    .i_valid (valid_x),
    .o_inst  (inst_mw),
    .o_pc    (pc_mw),
    .o_valid (valid_mw)
  );

  // Free-running cycle counter and a retire counter that advances for
  // every valid instruction sitting in MW; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= 32'h0;
      r_instret_cnt <= 32'h0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (valid_mw) begin
        r_instret_cnt <= r_instret_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;

endmodule

// File: tb/tb_fetch_pipe.sv
// Self-checking bench for fetch_pipe: a directed table, a randomized run
// against a behavioural model, and counter wrap-around.
module tb_fetch_pipe;
  import riscv_pkg::*;

  localparam logic [31:0] BOOT_PC = 32'h4000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_sel;
  logic [31:0] jal_target;
  logic [31:0] alu_out;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] pc_fd;
  logic [31:0] inst_fd;
  logic [31:0] inst_x;
  logic [31:0] pc_x;
  logic        valid_x;
  logic [31:0] inst_mw;
  logic [31:0] pc_mw;
  logic        valid_mw;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  int nVectors = 0;
  int nMiscompares = 0;

  // Behavioural model state
  logic [31:0] mPc;
  logic [31:0] mXInst, mXPc, mMwInst, mMwPc;
  logic        mXValid, mMwValid, mXPcKnown, mMwPcKnown;
  logic [31:0] mCycle, mInstret;
  logic        mLive = 1'b0;

  typedef struct {
    logic        rst;
    logic [1:0]  sel;
    logic        stall;
    logic [31:0] jal;
    logic [31:0] alu;
    logic [31:0] eAddr;
    logic [31:0] ePcFd;
    logic        eValidX;
  } vec_t;

  vec_t table_v[17];

  always #5 clk = ~clk;

  fetch_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .pc_sel      (pc_sel),
    .jal_target  (jal_target),
    .alu_out     (alu_out),
    .stall       (stall),
    .imem_addr   (imem_addr),
    .imem_dout   (imem_dout),
    .pc_fd       (pc_fd),
    .inst_fd     (inst_fd),
    .inst_x      (inst_x),
    .pc_x        (pc_x),
    .valid_x     (valid_x),
    .inst_mw     (inst_mw),
    .pc_mw       (pc_mw),
    .valid_mw    (valid_mw),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  // Address-dependent instruction contents so every fetch is identifiable.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0080;
  endfunction

  // Synchronous-read instruction memory
  always @(posedge clk) imem_dout <= memWord(imem_addr);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model after an edge.
  task automatic checkModel();
    checkOutput("pc_fd", pc_fd, mPc);
    checkOutput("inst_fd", inst_fd, memWord(mPc));
    checkOutput("inst_x", inst_x, mXInst);
    checkOutput("valid_x", {31'b0, valid_x}, {31'b0, mXValid});
    if (mXPcKnown) checkOutput("pc_x", pc_x, mXPc);
    checkOutput("inst_mw", inst_mw, mMwInst);
    checkOutput("valid_mw", {31'b0, valid_mw}, {31'b0, mMwValid});
    if (mMwPcKnown) checkOutput("pc_mw", pc_mw, mMwPc);
    checkOutput("cycle_cnt", cycle_cnt, mCycle);
    checkOutput("instret_cnt", instret_cnt, mInstret);
  endtask

  // Drive one cycle of inputs, check the fetch address, clock, update the
  // model from the architectural rules and check all outputs.
  task automatic applyStimulus(input logic iRst, input logic [1:0] iSel, input logic iStall,
                               input logic [31:0] iJal, input logic [31:0] iAlu,
                               output logic [31:0] sampledAddr);
    logic [31:0] expAddr;
    @(negedge clk);
    rst = iRst;
    pc_sel = iSel;
    stall = iStall;
    jal_target = iJal;
    alu_out = iAlu;
    #1;
    if (iRst)              expAddr = BOOT_PC;
    else if (iSel == 2'd1) expAddr = {iAlu[31:1], 1'b0};
    else if (iStall)       expAddr = mPc;
    else if (iSel == 2'd0) expAddr = iJal;
    else                   expAddr = mPc + 32'd4;
    sampledAddr = imem_addr;
    if (iRst || mLive) checkOutput("imem_addr", imem_addr, expAddr);
    @(posedge clk);
    #1;
    if (iRst) begin
      mPc = BOOT_PC;
      mXInst = NOP; mXPc = 32'h0; mXValid = 1'b0; mXPcKnown = 1'b1;
      mMwInst = NOP; mMwPc = 32'h0; mMwValid = 1'b0; mMwPcKnown = 1'b1;
      mCycle = 32'h0; mInstret = 32'h0;
      mLive = 1'b1;
    end else if (mLive) begin
      if (mMwValid) mInstret = mInstret + 32'd1;
      mCycle = mCycle + 32'd1;
      mMwInst = mXInst; mMwPc = mXPc; mMwValid = mXValid; mMwPcKnown = mXPcKnown;
      if (iSel == 2'd1 || iStall) begin
        mXInst = NOP; mXValid = 1'b0; mXPcKnown = 1'b0;
      end else begin
        mXInst = memWord(mPc); mXPc = mPc; mXValid = 1'b1; mXPcKnown = 1'b1;
      end
      mPc = expAddr;
    end
    if (mLive) checkModel();
  endtask

  initial begin
    logic [31:0] addr;
    rst = 1'b1; pc_sel = 2'd2; stall = 1'b0; jal_target = 32'h0; alu_out = 32'h0;

    table_v[0]  = '{1'b1, 2'd2, 1'b0, 32'h0,         32'h0,         32'h4000_0000, 32'h4000_0000, 1'b0};
    table_v[1]  = '{1'b1, 2'd2, 1'b0, 32'h0,         32'h0,         32'h4000_0000, 32'h4000_0000, 1'b0};
    table_v[2]  = '{1'b0, 2'd2, 1'b0, 32'h0,         32'h0,         32'h4000_0004, 32'h4000_0004, 1'b1};
    table_v[3]  = '{1'b0, 2'd2, 1'b0, 32'h0,         32'h0,         32'h4000_0008, 32'h4000_0008, 1'b1};
    table_v[4]  = '{1'b0, 2'd2, 1'b0, 32'h0,         32'h0,         32'h4000_000C, 32'h4000_000C, 1'b1};
    table_v[5]  = '{1'b0, 2'd2, 1'b0, 32'h0,         32'h0,         32'h4000_0010, 32'h4000_0010, 1'b1};
    table_v[6]  = '{1'b0, 2'd0, 1'b0, 32'h4000_0100, 32'h0,         32'h4000_0100, 32'h4000_0100, 1'b1};
    table_v[7]  = '{1'b0, 2'd1, 1'b0, 32'h0,         32'h4000_0201, 32'h4000_0200, 32'h4000_0200, 1'b0};
    table_v[8]  = '{1'b0, 2'd2, 1'b0, 32'h0,         32'h0,         32'h4000_0204, 32'h4000_0204, 1'b1};
    table_v[9]  = '{1'b0, 2'd2, 1'b1, 32'h0,         32'h0,         32'h4000_0204, 32'h4000_0204, 1'b0};
    table_v[10] = '{1'b0, 2'd0, 1'b1, 32'h1234_5678, 32'h0,         32'h4000_0204, 32'h4000_0204, 1'b0};
    table_v[11] = '{1'b0, 2'd1, 1'b1, 32'h0,         32'h4000_0040, 32'h4000_0040, 32'h4000_0040, 1'b0};
    table_v[12] = '{1'b0, 2'd2, 1'b0, 32'h0,         32'h0,         32'h4000_0044, 32'h4000_0044, 1'b1};
    table_v[13] = '{1'b0, 2'd1, 1'b0, 32'h0,         32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    table_v[14] = '{1'b0, 2'd2, 1'b0, 32'h0,         32'h0,         32'h0000_0000, 32'h0000_0000, 1'b1};
    table_v[15] = '{1'b1, 2'd1, 1'b0, 32'h0,         32'h4000_0201, 32'h4000_0000, 32'h4000_0000, 1'b0};
    table_v[16] = '{1'b0, 2'd3, 1'b0, 32'h0,         32'h0,         32'h4000_0004, 32'h4000_0004, 1'b1};

    $display("[TB] directed table");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(table_v[i].rst, table_v[i].sel, table_v[i].stall,
                    table_v[i].jal, table_v[i].alu, addr);
      checkOutput($sformatf("tbl%0d_addr", i), addr, table_v[i].eAddr);
      checkOutput($sformatf("tbl%0d_pc_fd", i), pc_fd, table_v[i].ePcFd);
      checkOutput($sformatf("tbl%0d_valid_x", i), {31'b0, valid_x}, {31'b0, table_v[i].eValidX});
    end

    $display("[TB] randomized run");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) == 0),
                    $urandom, $urandom, addr);
    end

    $display("[TB] counter wrap");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, addr);
    checkOutput("wrap_pre_valid_mw", {31'b0, valid_mw}, 32'h1);
    force dut.r_instret_cnt = 32'hFFFF_FFFF;
    force dut.r_cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret_cnt;
    release dut.r_cycle_cnt;
    mInstret = 32'hFFFF_FFFF;
    mCycle = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, addr);
    checkOutput("instretWrap", instret_cnt, 32'h0);
    checkOutput("cycleWrap", cycle_cnt, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
